// File: rtl/best_gain_tracker.sv
// best_gain_tracker: tracks the highest-gain candidate over a round of beats.
// Ports: clk, reset (async, active-high)
//   in_*  : candidate stream (valid/ready/last, gain, assignments, tie mode)
//   out_* : round result (valid/ready, best gain/assignments, count, overflow)
// Build option: define BEST_GAIN_TRACKER_INDEX_EN to add out_best_index.
module best_gain_tracker #(
    parameter int MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX = 1,
    parameter int MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX = 1,
    parameter int MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE       = 4,
    parameter int MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE       = 1,
    parameter int MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX          = 2,
    parameter int MAXIMUM_BIT_WIDTH_OF_CANDIDATE_INDEX        = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic in_tie_mode,
    input  logic in_valid,
    output logic in_ready,
    input  logic in_last,
    input  logic [MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX:0] in_gain,
    input  logic [MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE*(2**MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX)-1:0] in_integer_assignment,
    input  logic [MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE*(2**MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX)-1:0] in_boolean_assignment,
    output logic out_valid,
    input  logic out_ready,
    output logic [MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX:0] out_best_gain,
    output logic [MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE*(2**MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX)-1:0] out_best_integer_assignment,
    output logic [MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE*(2**MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX)-1:0] out_best_boolean_assignment,
`ifdef BEST_GAIN_TRACKER_INDEX_EN
    output logic [MAXIMUM_BIT_WIDTH_OF_CANDIDATE_INDEX-1:0] out_best_index,
`endif
    output logic [MAXIMUM_BIT_WIDTH_OF_CANDIDATE_INDEX:0] out_candidate_count,
    output logic out_overflow
);

    localparam int G  = MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX + 1;
    localparam int C  = MAXIMUM_BIT_WIDTH_OF_CANDIDATE_INDEX;
    localparam int IW = MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE
                        * (2**MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX);
    localparam int BW = MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE
                        * (2**MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX);

    localparam logic [C:0] CNT_ONE = {{C{1'b0}}, 1'b1};
    localparam logic [C:0] CNT_MAX = {1'b1, {C{1'b0}}};

    typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_t;

    state_t          state_q, state_d;
    logic            first_q, first_d;
    logic            tie_q, tie_d;
    logic [G-1:0]    gain_q, gain_d;
    logic [IW-1:0]   iasg_q, iasg_d;
    logic [BW-1:0]   basg_q, basg_d;
    logic [C:0]      count_q, count_d;
    logic            ovf_q, ovf_d;
    logic            accept;
    logic            better;

`ifdef BEST_GAIN_TRACKER_INDEX_EN
    logic [C-1:0]    idx_q, idx_d;
    logic [C-1:0]    pos;

    // Arrival position of the current beat; pinned to the last slot once full.
    assign pos = (count_q == CNT_MAX) ? {C{1'b1}} : count_q[C-1:0];
    assign out_best_index = idx_q;
`endif

    assign in_ready  = (state_q == COLLECT) && !reset;
    assign out_valid = (state_q == HOLD);
    assign accept    = in_valid && in_ready;
    assign better    = (in_gain > gain_q) || ((in_gain == gain_q) && tie_q);

    assign out_best_gain               = gain_q;
    assign out_best_integer_assignment = iasg_q;
    assign out_best_boolean_assignment = basg_q;
    assign out_candidate_count         = count_q;
    assign out_overflow                = ovf_q;

    always_comb begin
        state_d = state_q;
        first_d = first_q;
        tie_d   = tie_q;
        gain_d  = gain_q;
        iasg_d  = iasg_q;
        basg_d  = basg_q;
        count_d = count_q;
        ovf_d   = ovf_q;
`ifdef BEST_GAIN_TRACKER_INDEX_EN
        idx_d   = idx_q;
`endif
        unique case (state_q)
            COLLECT: begin
                if (accept) begin
                    if (first_q) begin
                        first_d = 1'b0;
                        tie_d   = in_tie_mode;
                        gain_d  = in_gain;
                        iasg_d  = in_integer_assignment;
                        basg_d  = in_boolean_assignment;
                        count_d = CNT_ONE;
                        ovf_d   = 1'b0;
`ifdef BEST_GAIN_TRACKER_INDEX_EN
                        idx_d   = '0;
`endif
                    end else begin
                        if (count_q == CNT_MAX) begin
                            ovf_d = 1'b1;
                        end else begin
                            count_d = count_q + CNT_ONE;
                        end
                        if (better) begin
                            gain_d = in_gain;
                            iasg_d = in_integer_assignment;
                            basg_d = in_boolean_assignment;
`ifdef BEST_GAIN_TRACKER_INDEX_EN
                            idx_d  = pos;
`endif
                        end
                    end
                    if (in_last) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                // Winner stays visible after the handshake until a new round starts.
                if (out_ready) begin
                    state_d = COLLECT;
                    first_d = 1'b1;
                    count_d = '0;
                    ovf_d   = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= COLLECT;
            first_q <= 1'b1;
            tie_q   <= 1'b0;
            gain_q  <= '0;
            iasg_q  <= '0;
            basg_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
`ifdef BEST_GAIN_TRACKER_INDEX_EN
            idx_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            first_q <= first_d;
            tie_q   <= tie_d;
            gain_q  <= gain_d;
            iasg_q  <= iasg_d;
            basg_q  <= basg_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
`ifdef BEST_GAIN_TRACKER_INDEX_EN
            idx_q   <= idx_d;
`endif
        end
    end

endmodule

// File: tb/tb_best_gain_tracker.sv
// tb_best_gain_tracker: directed checks of best_gain_tracker.
// Gain width widened to 4 bits so a gain of 8 is representable.
module tb_best_gain_tracker;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_tie_mode;
    logic       in_valid;
    logic       in_ready;
    logic       in_last;
    logic [3:0] in_gain;
    logic [7:0] in_ia;
    logic [1:0] in_ba;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_gain;
    logic [7:0] out_ia;
    logic [1:0] out_ba;
    logic [3:0] out_count;
    logic       out_ovf;
`ifdef BEST_GAIN_TRACKER_INDEX_EN
    logic [2:0] out_idx;
`endif

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    best_gain_tracker #(
        .MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX(3),
        .MAXIMUM_BIT_WIDTH_OF_CANDIDATE_INDEX(3)
    ) dut (
        .clk                         (clk),
        .reset                       (reset),
        .in_tie_mode                 (in_tie_mode),
        .in_valid                    (in_valid),
        .in_ready                    (in_ready),
        .in_last                     (in_last),
        .in_gain                     (in_gain),
        .in_integer_assignment       (in_ia),
        .in_boolean_assignment       (in_ba),
        .out_valid                   (out_valid),
        .out_ready                   (out_ready),
        .out_best_gain               (out_gain),
        .out_best_integer_assignment (out_ia),
        .out_best_boolean_assignment (out_ba),
`ifdef BEST_GAIN_TRACKER_INDEX_EN
        .out_best_index              (out_idx),
`endif
        .out_candidate_count         (out_count),
        .out_overflow                (out_ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Drive one beat; returns #1 after the accepting edge.
    task automatic beat(input logic [3:0] g, input logic [7:0] ia,
                        input logic [1:0] ba, input logic last,
                        input logic tie);
        in_valid    = 1'b1;
        in_gain     = g;
        in_ia       = ia;
        in_ba       = ba;
        in_last     = last;
        in_tie_mode = tie;
        chk("in_ready_before_beat", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("hs_out_valid", 32'(out_valid), 32'd0);
        chk("hs_in_ready", 32'(in_ready), 32'd1);
        chk("hs_count_cleared", 32'(out_count), 32'd0);
    endtask

    initial begin
        reset       = 1'b1;
        in_tie_mode = 1'b0;
        in_valid    = 1'b0;
        in_last     = 1'b0;
        in_gain     = '0;
        in_ia       = '0;
        in_ba       = '0;
        out_ready   = 1'b0;
        #3;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_gain", 32'(out_gain), 32'd0);
        chk("rst_count", 32'(out_count), 32'd0);
        chk("rst_ovf", 32'(out_ovf), 32'd0);
        chk("rst_ia", 32'(out_ia), 32'd0);
`ifdef BEST_GAIN_TRACKER_INDEX_EN
        chk("rst_idx", 32'(out_idx), 32'd0);
`endif
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Round 1: gains 2,5,3,5 tie mode 0 -> first 5 kept
        beat(4'd2, 8'h11, 2'b01, 1'b0, 1'b0);
        beat(4'd5, 8'h22, 2'b10, 1'b0, 1'b0);
        beat(4'd3, 8'h33, 2'b11, 1'b0, 1'b0);
        chk("r1_out_valid_early", 32'(out_valid), 32'd0);
        beat(4'd5, 8'h44, 2'b00, 1'b1, 1'b0);
        chk("r1_out_valid", 32'(out_valid), 32'd1);
        chk("r1_in_ready", 32'(in_ready), 32'd0);
        chk("r1_gain", 32'(out_gain), 32'd5);
        chk("r1_ia", 32'(out_ia), 32'h22);
        chk("r1_ba", 32'(out_ba), 32'h2);
        chk("r1_count", 32'(out_count), 32'd4);
        chk("r1_ovf", 32'(out_ovf), 32'd0);
`ifdef BEST_GAIN_TRACKER_INDEX_EN
        chk("r1_idx", 32'(out_idx), 32'd1);
`endif
        handshake();
        chk("r1_gain_retained", 32'(out_gain), 32'd5);
        chk("r1_ia_retained", 32'(out_ia), 32'h22);

        // Round 2: same stream, tie mode 1 latched on first beat only
        beat(4'd2, 8'h11, 2'b01, 1'b0, 1'b1);
        beat(4'd5, 8'h22, 2'b10, 1'b0, 1'b0);
        beat(4'd3, 8'h33, 2'b11, 1'b0, 1'b0);
        beat(4'd5, 8'h44, 2'b00, 1'b1, 1'b0);
        chk("r2_out_valid", 32'(out_valid), 32'd1);
        chk("r2_gain", 32'(out_gain), 32'd5);
        chk("r2_ia", 32'(out_ia), 32'h44);
        chk("r2_ba", 32'(out_ba), 32'h0);
        chk("r2_count", 32'(out_count), 32'd4);
`ifdef BEST_GAIN_TRACKER_INDEX_EN
        chk("r2_idx", 32'(out_idx), 32'd3);
`endif
        handshake();

        // Round 3: single beat of gain 0
        beat(4'd0, 8'h5a, 2'b10, 1'b1, 1'b0);
        chk("r3_out_valid", 32'(out_valid), 32'd1);
        chk("r3_gain", 32'(out_gain), 32'd0);
        chk("r3_ia", 32'(out_ia), 32'h5a);
        chk("r3_count", 32'(out_count), 32'd1);
        chk("r3_ovf", 32'(out_ovf), 32'd0);
        handshake();

        // Round 4: nine beats gains 0..8 -> overflow on ninth
        for (int i = 0; i < 8; i++) begin
            beat(4'(i), 8'(i + 8'h80), 2'(i), 1'b0, 1'b0);
        end
        chk("r4_count_full", 32'(out_count), 32'd8);
        chk("r4_ovf_not_yet", 32'(out_ovf), 32'd0);
        beat(4'd8, 8'h88, 2'b11, 1'b1, 1'b0);
        chk("r4_out_valid", 32'(out_valid), 32'd1);
        chk("r4_gain", 32'(out_gain), 32'd8);
        chk("r4_ia", 32'(out_ia), 32'h88);
        chk("r4_count", 32'(out_count), 32'd8);
        chk("r4_ovf", 32'(out_ovf), 32'd1);
`ifdef BEST_GAIN_TRACKER_INDEX_EN
        chk("r4_idx", 32'(out_idx), 32'd7);
`endif
        // Hold with out_ready low while a stray high-gain beat is offered
        in_valid = 1'b1;
        in_gain  = 4'd15;
        in_ia    = 8'hff;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("r4_hold_valid", 32'(out_valid), 32'd1);
            chk("r4_hold_ready", 32'(in_ready), 32'd0);
            chk("r4_hold_gain", 32'(out_gain), 32'd8);
            chk("r4_hold_ia", 32'(out_ia), 32'h88);
            chk("r4_hold_count", 32'(out_count), 32'd8);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        handshake();
        chk("r4_ovf_cleared", 32'(out_ovf), 32'd0);

        // Round 5: reset after two beats, then a fresh round of equal gains
        beat(4'd7, 8'h77, 2'b01, 1'b0, 1'b1);
        beat(4'd6, 8'h66, 2'b10, 1'b0, 1'b1);
        reset = 1'b1;
        #1;
        chk("r5_rst_in_ready", 32'(in_ready), 32'd0);
        chk("r5_rst_gain", 32'(out_gain), 32'd0);
        chk("r5_rst_count", 32'(out_count), 32'd0);
        chk("r5_rst_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        beat(4'd1, 8'ha1, 2'b01, 1'b0, 1'b0);
        beat(4'd1, 8'hb2, 2'b10, 1'b0, 1'b0);
        beat(4'd1, 8'hc3, 2'b11, 1'b1, 1'b0);
        chk("r5_out_valid", 32'(out_valid), 32'd1);
        chk("r5_gain", 32'(out_gain), 32'd1);
        chk("r5_ia", 32'(out_ia), 32'ha1);
        chk("r5_ba", 32'(out_ba), 32'h1);
        chk("r5_count", 32'(out_count), 32'd3);
        chk("r5_ovf", 32'(out_ovf), 32'd0);
`ifdef BEST_GAIN_TRACKER_INDEX_EN
        chk("r5_idx", 32'(out_idx), 32'd0);
`endif
        handshake();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
